// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense side.
// Holds the dispenser state enum, timing defaults and I/O polarities.
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SPIN      = 3'd1,
    S_WAIT_DROP = 3'd2,
    S_DONE      = 3'd3,
    S_PAYOUT    = 3'd4,
    S_FAULT     = 3'd5
  } disp_state_t;

  localparam int DEF_MOTOR_CYCLES   = 16;
  localparam int DEF_DROP_TIMEOUT   = 64;
  localparam int DEF_HOPPER_TIMEOUT = 32;

  // Polarities shared with the credit FSM.
  localparam logic CMD_ACTIVE    = 1'b1;
  localparam logic SENSOR_ACTIVE = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vend_edge_det.sv
// Registered rising-edge detector, async active-low reset.
// Ports: clk, resetn, x (level in), rise (x high, was low last cycle).
module vend_edge_det (
  input  logic clk,
  input  logic resetn,
  input  logic x,
  output logic rise
);

  logic x_q;
  logic armed;

  // armed masks the first cycle after reset so a level held
  // high through reset is not mistaken for a fresh edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q   <= 1'b0;
      armed <= 1'b0;
    end else begin
      x_q   <= x;
      armed <= 1'b1;
    end
  end

  assign rise = x && !x_q && armed;

endmodule

// File: rtl/vend_dispenser.sv
// Dispense responder: motor, drop wait, received pulse, opt. hopper.
// Ports: clk, resetn, drink, change, drop_sensor, coin_sensor,
//   fault_clr -> motor, hopper, received, busy, fault.
//   Macro VEND_CHANGE_HOPPER_EN compiles in PAYOUT / chg_pend.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int MOTOR_CYCLES   = DEF_MOTOR_CYCLES,
  parameter int DROP_TIMEOUT   = DEF_DROP_TIMEOUT,
  parameter int HOPPER_TIMEOUT = DEF_HOPPER_TIMEOUT
) (
  input  logic clk,
  input  logic resetn,
  input  logic drink,
  input  logic change,
  input  logic drop_sensor,
  input  logic coin_sensor,
  input  logic fault_clr,
  output logic motor,
  output logic hopper,
  output logic received,
  output logic busy,
  output logic fault
);

`ifdef VEND_CHANGE_HOPPER_EN
  localparam int CNT_MAX =
    max2(max2(MOTOR_CYCLES, DROP_TIMEOUT), HOPPER_TIMEOUT);
`else
  localparam int CNT_MAX = max2(MOTOR_CYCLES, DROP_TIMEOUT);
`endif
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] MC_LAST = CW'(MOTOR_CYCLES - 1);
  localparam logic [CW-1:0] DT_LAST = CW'(DROP_TIMEOUT - 1);

  disp_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic drink_rise;
  logic drop_hit;
  logic clr_hit;
  logic pend;

  assign drop_hit = (drop_sensor == SENSOR_ACTIVE);
  assign clr_hit  = (fault_clr == CMD_ACTIVE);

  vend_edge_det u_drink_ed (
    .clk    (clk),
    .resetn (resetn),
    .x      (drink == CMD_ACTIVE),
    .rise   (drink_rise)
  );

`ifdef VEND_CHANGE_HOPPER_EN
  localparam logic [CW-1:0] HT_LAST = CW'(HOPPER_TIMEOUT - 1);

  logic chg_rise;
  logic chg_pend_q, chg_pend_d;
  logic coin_hit;
  logic chg_clr;

  assign coin_hit = (coin_sensor == SENSOR_ACTIVE);

  vend_edge_det u_change_ed (
    .clk    (clk),
    .resetn (resetn),
    .x      (change == CMD_ACTIVE),
    .rise   (chg_rise)
  );

  assign chg_clr =
    (state_q == S_PAYOUT && coin_hit) ||
    (state_q == S_FAULT && clr_hit);

  // A new request beats a same-cycle clear.
  always_comb begin
    chg_pend_d = chg_pend_q;
    if (chg_rise)
      chg_pend_d = 1'b1;
    else if (chg_clr)
      chg_pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      chg_pend_q <= 1'b0;
    else
      chg_pend_q <= chg_pend_d;
  end

  assign pend = chg_pend_q;
`else
  logic unused_in;
  assign unused_in = ^{change, coin_sensor};
  assign pend = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (drink_rise)
          state_d = S_SPIN;
`ifdef VEND_CHANGE_HOPPER_EN
        else if (pend)
          state_d = S_PAYOUT;
`endif
      end
      S_SPIN: begin
        if (drop_hit)
          state_d = S_DONE;
        else if (cnt_q == MC_LAST)
          state_d = S_WAIT_DROP;
      end
      S_WAIT_DROP: begin
        if (drop_hit)
          state_d = S_DONE;
        else if (cnt_q == DT_LAST)
          state_d = S_FAULT;
      end
      S_DONE: begin
        state_d = pend ? S_PAYOUT : S_IDLE;
      end
`ifdef VEND_CHANGE_HOPPER_EN
      S_PAYOUT: begin
        if (coin_hit)
          state_d = S_IDLE;
        else if (cnt_q == HT_LAST)
          state_d = S_FAULT;
      end
`endif
      S_FAULT: begin
        if (clr_hit)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every state entry restarts the count; otherwise saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = '0;
    else if (cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign motor    = (state_q == S_SPIN);
  assign received = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE);
  assign fault    = (state_q == S_FAULT);
`ifdef VEND_CHANGE_HOPPER_EN
  assign hopper   = (state_q == S_PAYOUT);
`else
  assign hopper   = 1'b0;
`endif

endmodule

// File: tb/tb_vend_dispenser.sv
// Self-checking bench for vend_dispenser.
// Vector table plus directed multi-cycle sequences.
module tb_vend_dispenser;

  logic clk = 1'b0;
  logic resetn;
  logic drink, change, drop_sensor, coin_sensor, fault_clr;
  logic motor, hopper, received, busy, fault;

  int total = 0;
  int bad = 0;

  // Output order: {motor, hopper, received, busy, fault}
  localparam logic [4:0] O_IDLE = 5'b00000;
  localparam logic [4:0] O_SPIN = 5'b10010;
  localparam logic [4:0] O_WAIT = 5'b00010;
  localparam logic [4:0] O_DONE = 5'b00110;
  localparam logic [4:0] O_PAY  = 5'b01010;
  localparam logic [4:0] O_FLT  = 5'b00011;

  typedef struct packed {
    logic       drink;
    logic       change;
    logic       drop;
    logic       coin;
    logic       fclr;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl [9];

  vend_dispenser dut (
    .clk         (clk),
    .resetn      (resetn),
    .drink       (drink),
    .change      (change),
    .drop_sensor (drop_sensor),
    .coin_sensor (coin_sensor),
    .fault_clr   (fault_clr),
    .motor       (motor),
    .hopper      (hopper),
    .received    (received),
    .busy        (busy),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [4:0] exp);
    logic [4:0] got;
    got = {motor, hopper, received, busy, fault};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (m h r b f)", name, got, exp);
    end
  endtask

  task automatic set_in(input logic d, input logic c, input logic dr,
                        input logic co, input logic fc);
    drink = d;
    change = c;
    drop_sensor = dr;
    coin_sensor = co;
    fault_clr = fc;
  endtask

  initial begin
    // drink, change, drop, coin, fclr, expected after the edge
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_SPIN};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_SPIN};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_SPIN};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_SPIN};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_DONE};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_IDLE};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_IDLE};

    // Reset with drink held high
    resetn = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("reset_state", O_IDLE);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk("held_drink_1", O_IDLE);
    tick();
    chk("held_drink_2", O_IDLE);

    // Vector table: basic vend, ignored edges/sensors
    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].drink, tbl[i].change, tbl[i].drop,
             tbl[i].coin, tbl[i].fclr);
      tick();
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Late drop: 16 motor cycles, drop in WAIT_DROP cycle 20
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("late_spin_first", O_SPIN);
    drink = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk($sformatf("late_spin%0d", i), O_SPIN);
    end
    tick();
    chk("late_wait1", O_WAIT);
    repeat (19) tick();
    chk("late_wait20", O_WAIT);
    drop_sensor = 1'b1;
    tick();
    chk("late_recv", O_DONE);
    drop_sensor = 1'b0;
    tick();
    chk("late_idle", O_IDLE);

    // Drop on last SPIN count beats the timeout
    drink = 1'b1;
    tick();
    drink = 1'b0;
    repeat (15) tick();
    chk("lastspin_pre", O_SPIN);
    drop_sensor = 1'b1;
    tick();
    chk("lastspin_drop", O_DONE);
    drop_sensor = 1'b0;
    tick();
    chk("lastspin_idle", O_IDLE);

    // Drop on last WAIT_DROP count beats the timeout
    drink = 1'b1;
    tick();
    drink = 1'b0;
    repeat (79) tick();
    chk("lastwait_pre", O_WAIT);
    drop_sensor = 1'b1;
    tick();
    chk("lastwait_drop", O_DONE);
    drop_sensor = 1'b0;
    tick();
    chk("lastwait_idle", O_IDLE);

    // Timeout to FAULT after 16+64 cycles in SPIN/WAIT
    drink = 1'b1;
    tick();
    drink = 1'b0;
    repeat (79) tick();
    chk("tmo_pre", O_WAIT);
    tick();
    chk("tmo_fault", O_FLT);
    drink = 1'b1;
    tick();
    chk("tmo_drink_ign", O_FLT);
    drink = 1'b0;
    tick();
    // drink edge together with fault_clr is ignored
    drink = 1'b1;
    fault_clr = 1'b1;
    tick();
    chk("tmo_clr", O_IDLE);
    fault_clr = 1'b0;
    tick();
    chk("tmo_clr_noedge", O_IDLE);
    drink = 1'b0;
    tick();
    drink = 1'b1;
    tick();
    chk("tmo_revend", O_SPIN);
    drop_sensor = 1'b1;
    tick();
    chk("tmo_revend_recv", O_DONE);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("tmo_revend_idle", O_IDLE);

    // Asynchronous reset in SPIN cycle 8 with drink held high
    drink = 1'b1;
    tick();
    chk("rst_spin1", O_SPIN);
    repeat (7) tick();
    chk("rst_spin8", O_SPIN);
    #3;
    resetn = 1'b0;
    #1;
    chk("rst_async", O_IDLE);
    #2;
    resetn = 1'b1;
    tick();
    chk("rst_rel1", O_IDLE);
    tick();
    chk("rst_rel2", O_IDLE);
    drink = 1'b0;
    tick();
    drink = 1'b1;
    tick();
    chk("rst_newvend", O_SPIN);
    drop_sensor = 1'b1;
    tick();
    chk("rst_newvend_recv", O_DONE);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rst_newvend_idle", O_IDLE);

`ifdef VEND_CHANGE_HOPPER_EN
    // Change requested during SPIN, paid after DONE
    drink = 1'b1;
    tick();
    change = 1'b1;
    tick();
    chk("chg_spin", O_SPIN);
    drop_sensor = 1'b1;
    tick();
    chk("chg_done", O_DONE);
    drop_sensor = 1'b0;
    tick();
    chk("chg_pay1", O_PAY);
    tick();
    chk("chg_pay2", O_PAY);
    tick();
    chk("chg_pay3", O_PAY);
    coin_sensor = 1'b1;
    tick();
    chk("chg_coin_idle", O_IDLE);
    coin_sensor = 1'b0;
    tick();
    chk("chg_no_repay", O_IDLE);

    // New request on the same cycle as the coin is kept
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    change = 1'b1;
    tick();
    chk("setclr_req", O_IDLE);
    change = 1'b0;
    tick();
    chk("setclr_pay", O_PAY);
    change = 1'b1;
    coin_sensor = 1'b1;
    tick();
    chk("setclr_both", O_IDLE);
    coin_sensor = 1'b0;
    tick();
    chk("setclr_repay", O_PAY);
    coin_sensor = 1'b1;
    tick();
    chk("setclr_coin2", O_IDLE);
    coin_sensor = 1'b0;
    tick();
    chk("setclr_done", O_IDLE);

    // Hopper timeout, fault_clr drops the pending coin
    change = 1'b0;
    tick();
    change = 1'b1;
    tick();
    change = 1'b0;
    tick();
    chk("hto_pay1", O_PAY);
    repeat (31) tick();
    chk("hto_pay32", O_PAY);
    tick();
    chk("hto_fault", O_FLT);
    fault_clr = 1'b1;
    tick();
    chk("hto_clr", O_IDLE);
    fault_clr = 1'b0;
    tick();
    chk("hto_pend_gone", O_IDLE);
`else
    // Without the hopper, change and coin_sensor do nothing
    change = 1'b1;
    tick();
    chk("nohop_chg1", O_IDLE);
    tick();
    chk("nohop_chg2", O_IDLE);
    coin_sensor = 1'b1;
    tick();
    chk("nohop_coin", O_IDLE);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drink = 1'b1;
    tick();
    drop_sensor = 1'b1;
    tick();
    chk("nohop_done", O_DONE);
    drop_sensor = 1'b0;
    tick();
    chk("nohop_done_idle", O_IDLE);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
